// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in, serial-out shift register with a valid/ready load handshake and
// a per-word symbol counter. A LENGTH*WIDTH-bit word is accepted and then
// presented as LENGTH symbols of WIDTH bits, one symbol per enabled clock.
// This block is the transmit-side partner of the serial-in/parallel-out shift
// block in the readout chain. It can send decimated words or configuration
// words over a symbol-serial path.
//
// Symbol order:
//   Default build       : most significant symbol first. A receiver that
//                         shifts left and inserts at the bottom rebuilds the
//                         original word after LENGTH enabled cycles.
//   PISO_LSB_FIRST_EN   : when this macro is defined, the least significant
//                         symbol goes first and the register shifts right.
//                         The handshake, counter and timing do not change.
//
// Parameters:
//   WIDTH   bits per serial symbol (>= 1)
//   LENGTH  symbols per parallel word (must be >= 2)
//
// Ports:
//   i_clk        clock, all logic on the rising edge
//   i_rst        synchronous active-high reset (wins over i_en)
//   i_en         clock enable; when low, all state holds
//   i_par        parallel word to send
//   i_valid      i_par is valid
//   o_ready      block can accept a word this cycle (combinational)
//   o_ser        current serial symbol (0 when idle)
//   o_ser_valid  o_ser holds a valid symbol
//   o_last       o_ser is the final symbol of the word
//   o_busy       word in flight; this is the FSM state (1 = SHIFT)
//
// Handshake: a word transfers on a rising edge where i_valid && o_ready.
// o_ready does not look at i_valid. Once i_valid is raised, the source holds
// i_par and i_valid stable until that transfer edge. o_ready goes high in IDLE
// and on the final-symbol cycle of a word, both only while i_en is high.
// Accepting on the final-symbol cycle gives back-to-back words with no gap.
// -----------------------------------------------------------------------------
module piso_serializer #(
    parameter int WIDTH  = 1,
    parameter int LENGTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic [LENGTH*WIDTH-1:0]   i_par,
    input  logic                      i_valid,
    output logic                      o_ready,
    output logic [WIDTH-1:0]          o_ser,
    output logic                      o_ser_valid,
    output logic                      o_last,
    output logic                      o_busy
);

    localparam int DW = LENGTH * WIDTH;
    localparam int CW = $clog2(LENGTH);

    // The counter holds the number of symbols still to come after the one on
    // o_ser. A freshly loaded word therefore starts at LENGTH-1.
    localparam logic [CW-1:0] CNT_LOAD = CW'(LENGTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t          state;
    logic [DW-1:0]   sreg;
    logic [CW-1:0]   cnt;

    logic            cnt_zero;
    logic            accept;
    logic [DW-1:0]   sreg_next_sym;
    logic [WIDTH-1:0] head_sym;

    assign cnt_zero = (cnt == '0);

    // The IDLE term is written out even though cnt is always 0 in IDLE.
    // This keeps the ready condition readable as "idle, or on the last symbol".
    assign o_ready = i_en & ((state == ST_IDLE) | ((state == ST_SHIFT) & cnt_zero));
    assign accept  = i_valid & o_ready;

`ifdef PISO_LSB_FIRST_EN
    // LSB-symbol first: read from the bottom, shift right, zero fill on top.
    assign head_sym      = sreg[WIDTH-1:0];
    assign sreg_next_sym = sreg >> WIDTH;
`else
    // MSB-symbol first: read from the top, shift left, zero fill at bottom.
    assign head_sym      = sreg[DW-1 -: WIDTH];
    assign sreg_next_sym = sreg << WIDTH;
`endif

    // -------------------------------------------------------------------------
    // Control FSM, shift register and counter.
    // When i_en is low, everything holds. No accept can happen then because
    // o_ready is gated by i_en.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else if (i_en) begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sreg  <= i_par;
                        cnt   <= CNT_LOAD;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_zero) begin
                        // Final symbol goes out on this edge. Either chain
                        // straight into the next word or drop back to IDLE.
                        if (accept) begin
                            sreg  <= i_par;
                            cnt   <= CNT_LOAD;
                            state <= ST_SHIFT;
                        end else begin
                            sreg  <= '0;
                            cnt   <= '0;
                            state <= ST_IDLE;
                        end
                    end else begin
                        sreg <= sreg_next_sym;
                        cnt  <= cnt - CW'(1);
                    end
                end
                default: begin
                    sreg  <= '0;
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Symbol outputs. These decode the state registers only, so they have no
    // combinational path from any input, and they freeze when i_en is low.
    // -------------------------------------------------------------------------
    assign o_busy      = (state == ST_SHIFT);
    assign o_ser_valid = o_busy;
    assign o_last      = o_busy & cnt_zero;
    assign o_ser       = o_busy ? head_sym : '0;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//
// Two instances of piso_serializer:
//   dut_a : WIDTH=1, LENGTH=8  (single word, back-to-back, enable freeze, reset)
//   dut_b : WIDTH=2, LENGTH=4  (loopback into a receiver shift model)
// Inputs change 1 time unit after a rising edge. Outputs are checked 1 time
// unit after that, well away from the next rising edge.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- dut_a (W=1, L=8) ----------------
    logic       en_a, valid_a, ready_a, sv_a, last_a, busy_a;
    logic [7:0] par_a;
    logic [0:0] ser_a;

    piso_serializer #(.WIDTH(1), .LENGTH(8)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en_a), .i_par(par_a), .i_valid(valid_a),
        .o_ready(ready_a), .o_ser(ser_a), .o_ser_valid(sv_a), .o_last(last_a),
        .o_busy(busy_a)
    );

    // ---------------- dut_b (W=2, L=4) ----------------
    logic       en_b, valid_b, ready_b, sv_b, last_b, busy_b;
    logic [7:0] par_b;
    logic [1:0] ser_b;

    piso_serializer #(.WIDTH(2), .LENGTH(4)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en_b), .i_par(par_b), .i_valid(valid_b),
        .o_ready(ready_b), .o_ser(ser_b), .o_ser_valid(sv_b), .o_last(last_b),
        .o_busy(busy_b)
    );

    // Receiver shift block: shifts left by WIDTH on every enabled edge and
    // inserts the incoming symbol at the bottom.
    logic [7:0] rx_par;
    always_ff @(posedge clk) begin
        if (rst)       rx_par <= '0;
        else if (en_b) rx_par <= {rx_par[5:0], ser_b};
    end

    // ---------------- expected symbol sequences ----------------
    // Each constant lists symbols in emission order: bit 7 first for W=1, and
    // bits [7:6] first for W=2.
`ifdef PISO_LSB_FIRST_EN
    localparam logic [7:0] SEQ_A5 = 8'b1010_0101;
    localparam logic [7:0] SEQ_3C = 8'b0011_1100;
    localparam logic [7:0] SEQ_F0 = 8'b0000_1111;
    localparam logic [7:0] SEQ_FF = 8'b1111_1111;
    localparam logic [7:0] SEQ_01 = 8'b1000_0000;
    localparam logic [7:0] SEQ_E4 = 8'b00_01_10_11;
`else
    localparam logic [7:0] SEQ_A5 = 8'b1010_0101;
    localparam logic [7:0] SEQ_3C = 8'b0011_1100;
    localparam logic [7:0] SEQ_F0 = 8'b1111_0000;
    localparam logic [7:0] SEQ_FF = 8'b1111_1111;
    localparam logic [7:0] SEQ_01 = 8'b0000_0001;
    localparam logic [7:0] SEQ_E4 = 8'b11_10_01_00;
`endif

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table for dut_a ----------------
    typedef struct packed {
        logic       valid;
        logic [7:0] par;
        logic       en;
        logic       ser;
        logic       sv;
        logic       last;
        logic       ready;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [7:0] p, input logic e,
                                input logic s, input logic svv, input logic l,
                                input logic r, input logic b);
        vec_t x;
        x.valid = v; x.par = p; x.en = e;
        x.ser = s; x.sv = svv; x.last = l; x.ready = r; x.busy = b;
        return x;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b1;
        en_a = 1'b1; valid_a = 1'b0; par_a = '0;
        en_b = 1'b1; valid_b = 1'b0; par_b = '0;

        // Reset state
        step();
        check("rst.ser",   32'(ser_a),   32'd0);
        check("rst.sv",    32'(sv_a),    32'd0);
        check("rst.last",  32'(last_a),  32'd0);
        check("rst.busy",  32'(busy_a),  32'd0);
        check("rst.ready_en1", 32'(ready_a), 32'd1);
        en_a = 1'b0;
        #1;
        check("rst.ready_en0", 32'(ready_a), 32'd0);
        en_a = 1'b1;
        rst  = 1'b0;
        step();

        // Table: single 0xA5 word, then 0xA5/0x3C back to back.
        tbl.push_back(mk(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(1'b0, 8'h00, 1'b1, SEQ_A5[7-k], 1'b1, k == 7, k == 7, 1'b1));
        tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(k >= 1, (k >= 1) ? 8'h3C : 8'h00, 1'b1,
                             SEQ_A5[7-k], 1'b1, k == 7, k == 7, 1'b1));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(1'b0, 8'h00, 1'b1, SEQ_3C[7-k], 1'b1, k == 7, k == 7, 1'b1));
        tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));

        foreach (tbl[i]) begin
            valid_a = tbl[i].valid;
            par_a   = tbl[i].par;
            en_a    = tbl[i].en;
            #1;
            check($sformatf("tbl%0d.ser",   i), 32'(ser_a),   32'(tbl[i].ser));
            check($sformatf("tbl%0d.sv",    i), 32'(sv_a),    32'(tbl[i].sv));
            check($sformatf("tbl%0d.last",  i), 32'(last_a),  32'(tbl[i].last));
            check($sformatf("tbl%0d.ready", i), 32'(ready_a), 32'(tbl[i].ready));
            check($sformatf("tbl%0d.busy",  i), 32'(busy_a),  32'(tbl[i].busy));
            step();
        end

        // Enable freeze: 0xF0, i_en low for 3 cycles after 2 symbols.
        valid_a = 1'b1; par_a = 8'hF0; en_a = 1'b1;
        #1;
        check("frz.ready_accept", 32'(ready_a), 32'd1);
        step();
        valid_a = 1'b0; par_a = '0;
        for (int k = 0; k < 2; k++) begin
            #1;
            check($sformatf("frz.ser%0d", k), 32'(ser_a), 32'(SEQ_F0[7-k]));
            step();
        end
        for (int j = 0; j < 3; j++) begin
            en_a = 1'b0;
            #1;
            check($sformatf("frz.hold%0d.ser", j),   32'(ser_a),   32'(SEQ_F0[5]));
            check($sformatf("frz.hold%0d.sv", j),    32'(sv_a),    32'd1);
            check($sformatf("frz.hold%0d.ready", j), 32'(ready_a), 32'd0);
            check($sformatf("frz.hold%0d.last", j),  32'(last_a),  32'd0);
            step();
        end
        en_a = 1'b1;
        for (int k = 2; k < 8; k++) begin
            #1;
            check($sformatf("frz.ser%0d", k),  32'(ser_a),  32'(SEQ_F0[7-k]));
            check($sformatf("frz.last%0d", k), 32'(last_a), 32'(k == 7));
            step();
        end
        #1;
        check("frz.idle.sv",   32'(sv_a),   32'd0);
        check("frz.idle.busy", 32'(busy_a), 32'd0);

        // Reset mid-word: 0xFF, i_rst (with i_en low) at symbol 4.
        valid_a = 1'b1; par_a = 8'hFF;
        step();
        valid_a = 1'b0; par_a = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("rmw.ser%0d", k), 32'(ser_a), 32'(SEQ_FF[7-k]));
            step();
        end
        #1;
        check("rmw.ser3", 32'(ser_a), 32'(SEQ_FF[4]));
        rst = 1'b1; en_a = 1'b0;
        step();
        rst = 1'b0; en_a = 1'b1;
        #1;
        check("rmw.after.ser",   32'(ser_a),   32'd0);
        check("rmw.after.sv",    32'(sv_a),    32'd0);
        check("rmw.after.busy",  32'(busy_a),  32'd0);
        check("rmw.after.last",  32'(last_a),  32'd0);
        check("rmw.after.ready", 32'(ready_a), 32'd1);
        valid_a = 1'b1; par_a = 8'h01;
        step();
        valid_a = 1'b0; par_a = '0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("rmw.w01.ser%0d", k),  32'(ser_a),  32'(SEQ_01[7-k]));
            check($sformatf("rmw.w01.last%0d", k), 32'(last_a), 32'(k == 7));
            step();
        end
        #1;
        check("rmw.w01.idle", 32'(sv_a), 32'd0);

        // Loopback: dut_b (W=2, L=4) with word 0xE4.
        valid_b = 1'b1; par_b = 8'hE4;
        #1;
        check("lb.ready", 32'(ready_b), 32'd1);
        step();
        valid_b = 1'b0; par_b = '0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("lb.ser%0d", k),  32'(ser_b),  32'(SEQ_E4[7-2*k -: 2]));
            check($sformatf("lb.sv%0d", k),   32'(sv_b),   32'd1);
            check($sformatf("lb.last%0d", k), 32'(last_b), 32'(k == 3));
            step();
        end
        #1;
`ifndef PISO_LSB_FIRST_EN
        check("lb.rx_par", 32'(rx_par), 32'h0000_00E4);
`endif
        check("lb.idle.busy", 32'(busy_b), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
